iiitb_piso_tx: RTL and testbench
================================

Name: iiitb_piso_tx

Overview:
Parallel-in serial-out transmitter. It accepts a WIDTH-bit word over a valid/ready load handshake and shifts it out one bit per clock on sdo, with framing strobes. It is the transmit end for the 4-bit SIPO shift-register receiver: sdo drives that receiver's serial input on the same clock. With the defaults, the receiver's parallel q holds the word exactly on the clock edge that ends the last-bit cycle.

Parameters:
- WIDTH, 4: data word width in bits; legal range 2..32.
- LSB_FIRST, 1: 1 sends bit 0 first; 0 sends bit WIDTH-1 first.
- GAP_CYCLES, 0: idle cycles inserted after each frame before the next load is accepted; legal range 0..15.

Ports:
- clk, input, 1: clock; all logic is on the rising edge.
- rst, input, 1: reset, synchronous, active-low.
- load_valid, input, 1: load_data is valid.
- load_ready, output, 1: the transmitter can accept a word.
- load_data, input, WIDTH: parallel word to send.
- sdo, output, 1: serial data out.
- sdo_valid, output, 1: sdo carries a frame bit this cycle.
- sdo_first, output, 1: high on the first bit of a frame.
- sdo_last, output, 1: high on the final bit of a frame.
- busy, output, 1: a frame or gap is in progress.

Behaviour:
- Clock and reset: clock clk; reset rst, synchronous, active-low.
- Registered outputs: all outputs are registered.
- Reset values (rst==0 at an edge): state IDLE; sdo=0, sdo_valid=0, sdo_first=0, sdo_last=0, busy=0, load_ready=0. The shift register and counters are cleared.
- After reset: load_ready rises one cycle after the first edge with rst==1.
- FSM states: IDLE, SHIFT, PAR (only with the optional feature), GAP.
- IDLE:
  - load_ready=1.
  - An accept occurs on an edge with load_valid && load_ready. At that edge: capture load_data, set bit count to 0, go to SHIFT, drop load_ready, set busy=1.
  - load_valid while load_ready=0 is ignored; nothing is latched.
- SHIFT, first cycle after accept: sdo = first bit, sdo_valid=1, sdo_first=1.
- SHIFT, following cycles: one bit per cycle for WIDTH consecutive cycles. Bit order is set by LSB_FIRST.
- SHIFT, last bit: sdo_last=1 on the cycle carrying the final data bit. Next state is GAP if GAP_CYCLES>0, otherwise IDLE.
- Mixed flags: sdo_first and sdo_last are never high together, because WIDTH>=2.
- GAP:
  - sdo=0, sdo_valid=0, busy=1, load_ready=0.
  - Lasts exactly GAP_CYCLES cycles, then IDLE.
- Outside a frame: sdo=0 whenever sdo_valid=0.
- Frame period: minimum accept-to-accept spacing is WIDTH+1+GAP_CYCLES cycles (WIDTH+2+GAP_CYCLES with parity). There is no overlap between frames.
- load_data changes while busy: have no effect; the word is captured only at accept.
- Reset mid-frame: the frame aborts at that edge and all outputs take their reset values. No partial frame resumes, and no sdo_last is issued for the aborted frame.
- Bit counter: width clog2(WIDTH+1). It saturates in SHIFT/PAR and is reloaded at accept.

Optional Feature:
- Macro: IIITB_PISO_PARITY_EN.
- Defined:
  - After the last data bit, state PAR sends one even-parity bit (XOR of all WIDTH captured bits) with sdo_valid=1.
  - sdo_last moves from the last data bit to the parity bit.
  - Frame length becomes WIDTH+1.
- Undefined: the PAR state and parity logic are absent; the frame is WIDTH bits.

Decomposition:
- Package iiitb_piso_pkg holds:
  - state encoding (IDLE=2'd0, SHIFT=2'd1, PAR=2'd2, GAP=2'd3);
  - default WIDTH=4;
  - the clog2-based counter-width constant function.
- Sub-module iiitb_piso_shreg holds:
  - load and shift of the data register;
  - bit counter with done flag;
  - running parity.
- The FSM, handshake and output registers live in iiitb_piso_tx.

Test Plan:
1. Basic frame (WIDTH=4, LSB_FIRST=1, GAP_CYCLES=0): accept 4'b1011 at cycle 0 -> sdo=1,1,0,1 on cycles 1-4, sdo_first on cycle 1, sdo_last on cycle 4; load_ready=1 again on cycle 5.
2. Loopback into the 4-bit SIPO (same clk, rst): send 4'b0110 -> SIPO q=4'b0110 and qbar=4'b1001 after the cycle-4 edge.
3. Order and gap (LSB_FIRST=0, GAP_CYCLES=3): load_valid held high continuously, words 4'hA then 4'h5 -> sdo=1,0,1,0, then 3 cycles with sdo_valid=0, then 0,1,0,1. Second accept occurs exactly 8 cycles after the first.
4. Parity (IIITB_PISO_PARITY_EN defined): 4'b1011 -> data 1,1,0,1 then parity 1 with sdo_last; 4'b1001 -> parity bit 0.
5. Reset mid-frame: rst=0 at cycle 2 of a frame -> next cycle all outputs 0. After release, load_ready=1 one cycle later and a new word 4'b1111 transmits intact.
6. Ignored inputs: change load_data and pulse load_valid during SHIFT -> transmitted bits unchanged and no extra frame.

Source files
------------

// File: rtl/iiitb_piso_pkg.sv
// Shared types and constants for the iiitb PISO transmitter.
// Optional parity frame bit is enabled by defining IIITB_PISO_PARITY_EN.
package iiitb_piso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam int DEF_WIDTH = 4;

  // Bit counter must be able to hold WIDTH itself so it can saturate there.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/iiitb_piso_shreg.sv
// Data shift register, saturating bit counter and running parity for the PISO.
// Parity accumulation exists only when IIITB_PISO_PARITY_EN is defined.
module iiitb_piso_shreg
  import iiitb_piso_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int LSB_FIRST = 1,
  parameter int CW        = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  output logic             next_bit,
  output logic             done,
  output logic             near_done
`ifdef IIITB_PISO_PARITY_EN
  ,
  output logic             parity
`endif
);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    cnt;

  // The head bit is already on sdo; the register supplies the bit behind it.
  assign shifted   = (LSB_FIRST != 0) ? (sreg >> 1) : (sreg << 1);
  assign next_bit  = (LSB_FIRST != 0) ? sreg[1] : sreg[WIDTH-2];
  assign done      = (cnt == CW'(WIDTH - 1));
  assign near_done = (cnt == CW'(WIDTH - 2));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: the data register is reset too, so an aborted word never leaks out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= data;
      cnt  <= '0;
    end else if (shift) begin
      sreg <= shifted;
      if (cnt != CW'(WIDTH)) cnt <= cnt + 1'b1;
    end
  end

`ifdef IIITB_PISO_PARITY_EN
  logic head;
  logic par_acc;

  assign head   = (LSB_FIRST != 0) ? sreg[0] : sreg[WIDTH-1];
  // Complete once the final data bit is at the head (done asserted).
  assign parity = par_acc ^ head;

  always_ff @(posedge clk) begin
    if (!rst || load) begin
      par_acc <= 1'b0;
    end else if (shift && (cnt != CW'(WIDTH))) begin
      par_acc <= par_acc ^ head;
    end
  end
`endif

endmodule

// File: rtl/iiitb_piso_tx.sv
// Parallel-in serial-out transmitter: valid/ready load, framed serial output.
// Define IIITB_PISO_PARITY_EN to append an even-parity bit to each frame.
module iiitb_piso_tx
  import iiitb_piso_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int LSB_FIRST  = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             sdo_first,
  output logic             sdo_last,
  output logic             busy
);

  localparam bit         HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [3:0] GAP_LOAD = HAS_GAP ? 4'(GAP_CYCLES - 1) : 4'd0;

  state_t     state;
  logic [3:0] gap_cnt;
  logic       accept;
  logic       first_bit;
  logic       shift;
  logic       next_bit;
  logic       done;
  logic       near_done;

  assign accept    = (state == IDLE) && load_valid && load_ready;
  assign first_bit = (LSB_FIRST != 0) ? load_data[0] : load_data[WIDTH-1];
  assign shift     = (state == SHIFT) || (state == PAR);

`ifdef IIITB_PISO_PARITY_EN
  logic parity;
`endif

  iiitb_piso_shreg #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_shreg (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .shift     (shift),
    .data      (load_data),
    .next_bit  (next_bit),
    .done      (done),
    .near_done (near_done)
`ifdef IIITB_PISO_PARITY_EN
    ,
    .parity    (parity)
`endif
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      gap_cnt    <= '0;
      sdo        <= 1'b0;
      sdo_valid  <= 1'b0;
      sdo_first  <= 1'b0;
      sdo_last   <= 1'b0;
      busy       <= 1'b0;
      load_ready <= 1'b0;
    end else begin
      // Strobes and data are pulses; states below re-assert them as needed.
      sdo       <= 1'b0;
      sdo_valid <= 1'b0;
      sdo_first <= 1'b0;
      sdo_last  <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            state      <= SHIFT;
            load_ready <= 1'b0;
            busy       <= 1'b1;
            sdo        <= first_bit;
            sdo_valid  <= 1'b1;
            sdo_first  <= 1'b1;
          end else begin
            load_ready <= 1'b1;
            busy       <= 1'b0;
          end
        end

        SHIFT: begin
          if (!done) begin
            sdo       <= next_bit;
            sdo_valid <= 1'b1;
`ifdef IIITB_PISO_PARITY_EN
            sdo_last  <= 1'b0;
`else
            sdo_last  <= near_done;
`endif
          end else begin
`ifdef IIITB_PISO_PARITY_EN
            state     <= PAR;
            sdo       <= parity;
            sdo_valid <= 1'b1;
            sdo_last  <= 1'b1;
`else
            if (HAS_GAP) begin
              state   <= GAP;
              gap_cnt <= GAP_LOAD;
            end else begin
              state      <= IDLE;
              busy       <= 1'b0;
              load_ready <= 1'b1;
            end
`endif
          end
        end

`ifdef IIITB_PISO_PARITY_EN
        PAR: begin
          if (HAS_GAP) begin
            state   <= GAP;
            gap_cnt <= GAP_LOAD;
          end else begin
            state      <= IDLE;
            busy       <= 1'b0;
            load_ready <= 1'b1;
          end
        end
`endif

        GAP: begin
          if (gap_cnt == 4'd0) begin
            state      <= IDLE;
            busy       <= 1'b0;
            load_ready <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end

        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          load_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iiitb_piso_tx.sv
// Directed bench for iiitb_piso_tx: default instance plus an MSB-first gapped one.
// Expectations adapt when IIITB_PISO_PARITY_EN is defined.
module tb_iiitb_piso_tx;

`ifdef IIITB_PISO_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk;
  logic       rst;
  logic       lv_a, lv_b;
  logic [3:0] ld_a, ld_b;
  logic       rdy_a, sdo_a, val_a, fst_a, lst_a, bsy_a;
  logic       rdy_b, sdo_b, val_b, fst_b, lst_b, bsy_b;

  iiitb_piso_tx dut_a (
    .clk (clk), .rst (rst), .load_valid (lv_a), .load_ready (rdy_a),
    .load_data (ld_a), .sdo (sdo_a), .sdo_valid (val_a), .sdo_first (fst_a),
    .sdo_last (lst_a), .busy (bsy_a)
  );

  iiitb_piso_tx #(.WIDTH (4), .LSB_FIRST (0), .GAP_CYCLES (3)) dut_b (
    .clk (clk), .rst (rst), .load_valid (lv_b), .load_ready (rdy_b),
    .load_data (ld_b), .sdo (sdo_b), .sdo_valid (val_b), .sdo_first (fst_b),
    .sdo_last (lst_b), .busy (bsy_b)
  );

  // Reference 4-bit SIPO receiver on the same clock and reset.
  logic [3:0] sipo_q;
  logic [3:0] sipo_qbar;
  always_ff @(posedge clk) begin
    if (!rst) sipo_q <= 4'b0000;
    else      sipo_q <= {sdo_a, sipo_q[3:1]};
  end
  assign sipo_qbar = ~sipo_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  // Output vector order: {load_ready, busy, sdo, sdo_valid, sdo_first, sdo_last}
  typedef struct {
    string      name;
    logic       rst;
    logic       lv;
    logic [3:0] ld;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic r, input logic v,
                     input logic [3:0] d, input logic [5:0] e);
    vec_t t;
    t.name = name; t.rst = r; t.lv = v; t.ld = d; t.exp = e;
    vecs.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b0;
    lv_a = 1'b0; ld_a = 4'h0;
    lv_b = 1'b0; ld_b = 4'h0;

    add("reset",        1'b0, 1'b0, 4'h0, 6'b000000);
    add("reset_load",   1'b0, 1'b1, 4'hF, 6'b000000);
    add("ready_rise",   1'b1, 1'b0, 4'h0, 6'b100000);
    add("f1_bit0",      1'b1, 1'b1, 4'hB, 6'b011110);
    add("f1_bit1",      1'b1, 1'b0, 4'h0, 6'b011100);
    add("f1_bit2_ign",  1'b1, 1'b1, 4'h0, 6'b010100);
`ifdef IIITB_PISO_PARITY_EN
    add("f1_bit3_ign",  1'b1, 1'b1, 4'h6, 6'b011100);
    add("f1_parity",    1'b1, 1'b0, 4'h0, 6'b011101);
`else
    add("f1_bit3_ign",  1'b1, 1'b1, 4'h6, 6'b011101);
`endif
    add("f1_idle",      1'b1, 1'b0, 4'h0, 6'b100000);
    add("f2_bit0",      1'b1, 1'b1, 4'hF, 6'b011110);
    add("f2_bit1",      1'b1, 1'b0, 4'h0, 6'b011100);
    add("abort_reset",  1'b0, 1'b0, 4'h0, 6'b000000);
    add("abort_ready",  1'b1, 1'b0, 4'h0, 6'b100000);
    add("f3_bit0",      1'b1, 1'b1, 4'hF, 6'b011110);
    add("f3_bit1",      1'b1, 1'b0, 4'h0, 6'b011100);
    add("f3_bit2",      1'b1, 1'b0, 4'h0, 6'b011100);
`ifdef IIITB_PISO_PARITY_EN
    add("f3_bit3",      1'b1, 1'b0, 4'h0, 6'b011100);
    add("f3_parity",    1'b1, 1'b0, 4'h0, 6'b010101);
`else
    add("f3_bit3",      1'b1, 1'b0, 4'h0, 6'b011101);
`endif
    add("f3_idle",      1'b1, 1'b0, 4'h0, 6'b100000);

    foreach (vecs[i]) begin
      rst  = vecs[i].rst;
      lv_a = vecs[i].lv;
      ld_a = vecs[i].ld;
      tick();
      check(vecs[i].name, 32'({rdy_a, bsy_a, sdo_a, val_a, fst_a, lst_a}), 32'(vecs[i].exp));
      if (i == 0)
        check("b_reset", 32'({rdy_b, bsy_b, sdo_b, val_b, fst_b, lst_b}), 32'd0);
    end
    lv_a = 1'b0;

    // MSB-first with gap, load_valid held high across two frames.
    begin
      int per;
      per = 4 + P + 3 + 1;
      check("b_ready", 32'(rdy_b), 32'd1);
      lv_b = 1'b1;
      ld_b = 4'hA;
      for (int k = 0; k < 2 * per; k++) begin
        int f, j;
        logic [3:0] w;
        logic [5:0] e;
        tick();
        if (k == 0) ld_b = 4'h5;
        f = k / per;
        j = k % per;
        w = (f != 0) ? 4'h5 : 4'hA;
        if (j < 4)
          e = {1'b0, 1'b1, w[3-j], 1'b1, 1'(j == 0), 1'((j == 3) && (P == 0))};
        else if (j < 4 + P)
          e = {1'b0, 1'b1, ^w, 1'b1, 1'b0, 1'b1};
        else if (j < 4 + P + 3)
          e = 6'b010000;
        else
          e = 6'b100000;
        check($sformatf("b_k%0d", k),
              32'({rdy_b, bsy_b, sdo_b, val_b, fst_b, lst_b}), 32'(e));
      end
      lv_b = 1'b0;
    end

    // Loopback into the SIPO receiver.
    check("lb_ready", 32'(rdy_a), 32'd1);
    lv_a = 1'b1;
    ld_a = 4'b0110;
    tick();
    lv_a = 1'b0;
    ld_a = 4'h0;
    for (int k = 1; k <= 4; k++) tick();
    check("lb_q",    32'(sipo_q),    32'(4'b0110));
    check("lb_qbar", 32'(sipo_qbar), 32'(4'b1001));
    tick();
    tick();
    check("lb_idle", 32'({rdy_a, bsy_a, val_a}), 32'(3'b100));

`ifdef IIITB_PISO_PARITY_EN
    // 4'b1001 carries zero parity.
    lv_a = 1'b1;
    ld_a = 4'b1001;
    tick();
    lv_a = 1'b0;
    tick();
    tick();
    tick();
    check("p9_bit3",   32'({sdo_a, val_a, lst_a}), 32'(3'b110));
    tick();
    check("p9_parity", 32'({sdo_a, val_a, lst_a}), 32'(3'b011));
    tick();
    check("p9_idle",   32'({rdy_a, bsy_a, val_a}), 32'(3'b100));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
